// File: rtl/pulse_generator.sv
// pulse_generator: programmable delay-then-width pulse FSM with pause, resume and abort.
module pulse_generator #(
  parameter int MAX_COUNT = 255,
  parameter bit PULSE_LEVEL = 1'b1,
  localparam int CW = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_generating,
  input  logic          stop_generating,
  input  logic          rst_generating,
  input  logic [CW-1:0] delay_cycles,
  input  logic [CW-1:0] width_cycles,
  output logic          pulse_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] counter_wire
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE, PAUSE} state_t;
  state_t state;
  logic [CW-1:0] counter, d_len, w_len;
  logic resume_pulse;
  assign busy = state != IDLE;
  assign counter_wire = counter;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      counter <= '0;
      d_len <= '0;
      w_len <= '0;
      resume_pulse <= 1'b0;
      pulse_out <= !PULSE_LEVEL;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start_generating) begin
          d_len <= delay_cycles;
          w_len <= width_cycles;
          if (width_cycles == '0) done <= 1'b1;
          else begin
            state <= delay_cycles == '0 ? PULSE : DELAY;
            counter <= CW'(1);
            pulse_out <= delay_cycles == '0 ? PULSE_LEVEL : !PULSE_LEVEL;
          end
        end
        DELAY: begin
          if (rst_generating) begin
            state <= IDLE;
            counter <= '0;
            pulse_out <= !PULSE_LEVEL;
          end else if (counter == d_len) begin
            state <= PULSE;
            counter <= CW'(1);
            pulse_out <= PULSE_LEVEL;
          end else if (stop_generating) begin
            state <= PAUSE;
            resume_pulse <= 1'b0;
          end else counter <= counter + 1'b1;
        end
        PULSE: begin
          if (rst_generating || counter == w_len) begin
            state <= IDLE;
            counter <= '0;
            pulse_out <= !PULSE_LEVEL;
            done <= !rst_generating;
          end else if (stop_generating) begin
            state <= PAUSE;
            resume_pulse <= 1'b1;
          end else counter <= counter + 1'b1;
        end
        default: begin
          // the resume edge counts as a normal step, so only cycles spent in PAUSE stretch the sequence
          if (rst_generating) begin
            state <= IDLE;
            counter <= '0;
            pulse_out <= !PULSE_LEVEL;
          end else if (start_generating && !stop_generating) begin
            state <= resume_pulse ? PULSE : DELAY;
            counter <= counter + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: table-driven and sequence checks for pulse_generator, active-high and active-low.
module tb_pulse_generator;
  logic clk = 1'b0, rst = 1'b1;
  logic start_generating = 1'b0, stop_generating = 1'b0, rst_generating = 1'b0;
  logic [7:0] delay_cycles = '0, width_cycles = '0;
  logic pulse_out, busy, done, pulse_n, busy_n, done_n;
  logic [7:0] counter_wire, counter_n;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pulse_generator #(.MAX_COUNT(255), .PULSE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .start_generating(start_generating), .stop_generating(stop_generating),
    .rst_generating(rst_generating), .delay_cycles(delay_cycles), .width_cycles(width_cycles),
    .pulse_out(pulse_out), .busy(busy), .done(done), .counter_wire(counter_wire));

  pulse_generator #(.MAX_COUNT(255), .PULSE_LEVEL(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start_generating(start_generating), .stop_generating(stop_generating),
    .rst_generating(rst_generating), .delay_cycles(delay_cycles), .width_cycles(width_cycles),
    .pulse_out(pulse_n), .busy(busy_n), .done(done_n), .counter_wire(counter_n));

  typedef struct {
    logic st, sp, rg;
    logic [7:0] d, w;
    logic p, b, dn;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(input logic st, sp, rg, input logic [7:0] d, w,
                              input logic p, b, dn, input logic [7:0] c);
    mk = '{st, sp, rg, d, w, p, b, dn, c};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic st, sp, rg, input logic [7:0] d, w);
    start_generating = st;
    stop_generating = sp;
    rst_generating = rg;
    delay_cycles = d;
    width_cycles = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int active, dones, rise, fall, maxc;
    tbl[0]  = mk(1,0,0,3,4, 0,1,0,1);
    tbl[1]  = mk(0,0,0,0,0, 0,1,0,2);
    tbl[2]  = mk(0,0,0,0,0, 0,1,0,3);
    tbl[3]  = mk(0,0,0,0,0, 1,1,0,1);
    tbl[4]  = mk(0,0,0,0,0, 1,1,0,2);
    tbl[5]  = mk(0,0,0,0,0, 1,1,0,3);
    tbl[6]  = mk(0,0,0,0,0, 1,1,0,4);
    tbl[7]  = mk(0,0,0,0,0, 0,0,1,0);
    tbl[8]  = mk(1,0,0,0,2, 1,1,0,1);
    tbl[9]  = mk(0,0,0,0,0, 1,1,0,2);
    tbl[10] = mk(0,0,0,0,0, 0,0,1,0);
    tbl[11] = mk(1,0,0,5,0, 0,0,1,0);
    tbl[12] = mk(0,0,0,0,0, 0,0,0,0);
    tbl[13] = mk(1,0,0,1,1, 0,1,0,1);
    tbl[14] = mk(1,1,0,7,7, 1,1,0,1);
    tbl[15] = mk(0,1,0,0,0, 0,0,1,0);
    tbl[16] = mk(1,1,0,2,1, 0,1,0,1);
    tbl[17] = mk(0,1,0,0,0, 0,1,0,1);
    tbl[18] = mk(0,0,0,0,0, 0,1,0,1);
    tbl[19] = mk(1,0,0,0,0, 0,1,0,2);
    tbl[20] = mk(0,0,0,0,0, 1,1,0,1);
    tbl[21] = mk(0,0,0,0,0, 0,0,1,0);
    tbl[22] = mk(1,0,0,4,3, 0,1,0,1);
    tbl[23] = mk(0,0,0,0,0, 0,1,0,2);
    tbl[24] = mk(0,0,1,0,0, 0,0,0,0);
    tbl[25] = mk(1,0,0,1,3, 0,1,0,1);
    tbl[26] = mk(0,0,0,0,0, 1,1,0,1);
    tbl[27] = mk(0,0,0,0,0, 1,1,0,2);
    tbl[28] = mk(0,0,1,0,0, 0,0,0,0);
    tbl[29] = mk(0,0,0,0,0, 0,0,0,0);
    tbl[30] = mk(1,0,0,0,1, 1,1,0,1);
    tbl[31] = mk(0,0,0,0,0, 0,0,1,0);

    step(0,0,0,0,0);
    step(0,0,0,0,0);
    chk("reset pulse", pulse_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset counter", counter_wire, 0);
    chk("reset pulse_n", pulse_n, 1);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].rg, tbl[i].d, tbl[i].w);
      chk($sformatf("vec%0d pulse", i), pulse_out, tbl[i].p);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
      chk($sformatf("vec%0d done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d counter", i), counter_wire, tbl[i].c);
      chk($sformatf("vec%0d pulse_n", i), pulse_n, !tbl[i].p);
    end

    step(1,0,0,2,5);
    active = 0;
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      step(k == 7, k >= 4 && k <= 6, 0, 0, 0);
      if (k == 5) begin
        chk("pause held pulse", pulse_out, 1);
        chk("pause busy", busy, 1);
        chk("pause counter", counter_wire, 2);
      end
      active += int'(pulse_out);
      dones += int'(done);
    end
    chk("pause active cycles", active, 8);
    chk("pause done count", dones, 1);

    step(1,0,0,255,255);
    rise = -1;
    fall = -1;
    dones = 0;
    maxc = 0;
    for (int k = 1; k <= 600; k++) begin
      step(0,0,0,0,0);
      if (pulse_out && rise < 0) rise = k;
      if (!pulse_out && rise >= 0 && fall < 0) fall = k;
      if (int'(counter_wire) > maxc) maxc = int'(counter_wire);
      dones += int'(done);
    end
    chk("max rise edge", rise, 255);
    chk("max fall edge", fall, 510);
    chk("max done count", dones, 1);
    chk("max counter peak", maxc, 255);

    step(1,0,0,0,5);
    chk("low-active pulse on", pulse_n, 0);
    step(0,0,0,0,0);
    rst = 1'b1;
    step(0,0,0,0,0);
    chk("rst mid-pulse pulse_n", pulse_n, 1);
    chk("rst mid-pulse busy_n", busy_n, 0);
    chk("rst mid-pulse done_n", done_n, 0);
    chk("rst mid-pulse counter_n", counter_n, 0);
    chk("rst mid-pulse pulse", pulse_out, 0);
    rst = 1'b0;
    step(0,0,0,0,0);
    chk("after rst done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
